// File: rtl/menu_pkg.sv
// Shared constants for the BMP-to-SRAM loader: header offsets, data floor and FSM encoding.
package menu_pkg;

    localparam int unsigned IOCTL_AW = 25;
    localparam int unsigned HDR_W    = 24;

    localparam logic [IOCTL_AW-1:0] HDR_OFS_B0   = 25'd10;
    localparam logic [IOCTL_AW-1:0] HDR_OFS_B1   = 25'd11;
    localparam logic [IOCTL_AW-1:0] HDR_OFS_B2   = 25'd12;
    localparam logic [IOCTL_AW-1:0] DATA_MIN_OFS = 25'd13;

    localparam logic [HDR_W-1:0] DATA_START_RST = 24'hFFFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD0,
        ST_RD1,
        ST_RD2,
        ST_RD3,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD
    } state_t;

endpackage

// File: rtl/bmp_hdr_parser.sv
// Captures the BMP pixel-data offset from the file header and maps accepted
// file bytes to SRAM byte addresses, flagging bytes that fall outside the SRAM.
module bmp_hdr_parser
    import menu_pkg::*;
#(
    parameter int unsigned SRAM_AW = 19
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                dl_rise,
    input  logic                accept,
    input  logic [IOCTL_AW-1:0] ioctl_addr,
    input  logic [7:0]          ioctl_dout,
    output logic                wr_hit_c,
    output logic                range_ovf_c,
    output logic [SRAM_AW-1:0]  wr_addr_c
);

    logic [HDR_W-1:0]    data_start;
    logic [IOCTL_AW-1:0] start_ext;
    logic [IOCTL_AW-1:0] diff;
    logic                in_data;
    logic                fits;

    // Offset restarts at all-ones so nothing is written before the header arrives
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            data_start <= DATA_START_RST;
        end else if (dl_rise) begin
            data_start <= DATA_START_RST;
        end else if (accept) begin
            case (ioctl_addr)
                HDR_OFS_B0: data_start[7:0]   <= ioctl_dout;
                HDR_OFS_B1: data_start[15:8]  <= ioctl_dout;
                HDR_OFS_B2: data_start[23:16] <= ioctl_dout;
                default:    ;
            endcase
        end
    end

    assign start_ext   = IOCTL_AW'(data_start);
    assign diff        = ioctl_addr - start_ext;
    assign in_data     = (ioctl_addr >= DATA_MIN_OFS) && (ioctl_addr >= start_ext);
    assign fits        = (diff >> SRAM_AW) == '0;
    assign wr_hit_c    = accept && in_data && fits;
    assign range_ovf_c = accept && in_data && !fits;
    assign wr_addr_c   = SRAM_AW'(diff);

endmodule

// File: rtl/sram_bmp_ctrl.sv
// Loads a BMP file byte stream into an async 8-bit SRAM and serves 32-bit
// pixel-word reads once the download has finished.
module sram_bmp_ctrl
    import menu_pkg::*;
#(
    parameter int unsigned SRAM_AW = 19
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                ioctl_download,
    input  logic                ioctl_wr,
    input  logic [IOCTL_AW-1:0] ioctl_addr,
    input  logic [7:0]          ioctl_dout,
    input  logic                pix_req,
    input  logic [SRAM_AW-3:0]  pix_addr,
    output logic [31:0]         pix_data,
    output logic                pix_valid,
    output logic                bmp_loaded,
    output logic                ovf,
    output logic [SRAM_AW-1:0]  sram_addr,
    output logic [7:0]          sram_dq_o,
    input  logic [7:0]          sram_dq_i,
    output logic                sram_dq_oe,
    output logic                sram_we_n
);

    localparam int unsigned WW = SRAM_AW - 2;

    state_t             state, state_d;
    logic               wr_q, dl_q;
    logic               accept, dl_rise, dl_fall;
    logic               wr_hit, range_ovf;
    logic [SRAM_AW-1:0] wr_addr;
    logic               buf_full;
    logic [SRAM_AW-1:0] buf_addr;
    logic [7:0]         buf_data;
    logic               rd_pend;
    logic [WW-1:0]      rd_word;
    logic               load_pend;
    logic [23:0]        rd_shift, rd_shift_d;
    logic [SRAM_AW-1:0] addr_d;
    logic [7:0]         dq_d;
    logic               oe_d, we_n_d, valid_d;
    logic [31:0]        pix_d;
    logic               rd_take, buf_free;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_q <= 1'b0;
            dl_q <= 1'b0;
        end else begin
            wr_q <= ioctl_wr;
            dl_q <= ioctl_download;
        end
    end

    assign accept  = ioctl_wr && !wr_q && ioctl_download;
    assign dl_rise = ioctl_download && !dl_q;
    assign dl_fall = !ioctl_download && dl_q;

    bmp_hdr_parser #(.SRAM_AW(SRAM_AW)) u_hdr (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .dl_rise     (dl_rise),
        .accept      (accept),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .wr_hit_c    (wr_hit),
        .range_ovf_c (range_ovf),
        .wr_addr_c   (wr_addr)
    );

    // Write buffer, pending read request, and load/overflow status
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            buf_full   <= 1'b0;
            buf_addr   <= '0;
            buf_data   <= '0;
            rd_pend    <= 1'b0;
            rd_word    <= '0;
            load_pend  <= 1'b0;
            bmp_loaded <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            if (buf_free) buf_full <= 1'b0;
            if (wr_hit && !buf_full) begin
                buf_full <= 1'b1;
                buf_addr <= wr_addr;
                buf_data <= ioctl_dout;
            end
            if (pix_req && !ioctl_download) begin
                rd_pend <= 1'b1;
                rd_word <= pix_addr;
            end else if (rd_take) begin
                rd_pend <= 1'b0;
            end
            if (dl_rise) begin
                ovf        <= 1'b0;
                bmp_loaded <= 1'b0;
                load_pend  <= 1'b0;
            end else begin
                if (range_ovf || (wr_hit && buf_full)) ovf <= 1'b1;
                if (dl_fall) begin
                    load_pend <= 1'b1;
                end else if (load_pend && !buf_full) begin
                    load_pend  <= 1'b0;
                    bmp_loaded <= 1'b1;
                end
            end
        end
    end

    // Next state and next registered SRAM/pixel outputs
    always_comb begin
        state_d    = state;
        addr_d     = sram_addr;
        dq_d       = sram_dq_o;
        oe_d       = sram_dq_oe;
        we_n_d     = 1'b1;
        pix_d      = pix_data;
        valid_d    = 1'b0;
        rd_shift_d = rd_shift;
        rd_take    = 1'b0;
        buf_free   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (buf_full) begin
                    state_d = ST_WR_SETUP;
                    addr_d  = buf_addr;
                    dq_d    = buf_data;
                    oe_d    = 1'b1;
                end else if (rd_pend && !ioctl_download) begin
                    state_d = ST_RD0;
                    addr_d  = {rd_word, 2'b00};
                    rd_take = 1'b1;
                end
            end
            ST_RD0, ST_RD1, ST_RD2: begin
                rd_shift_d = {rd_shift[15:0], sram_dq_i};
                addr_d     = sram_addr + SRAM_AW'(1);
                state_d    = (state == ST_RD0) ? ST_RD1 :
                             (state == ST_RD1) ? ST_RD2 : ST_RD3;
            end
            ST_RD3: begin
                pix_d   = {rd_shift, sram_dq_i};
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            ST_WR_SETUP: begin
                we_n_d  = 1'b0;
                state_d = ST_WR_PULSE;
            end
            ST_WR_PULSE: begin
                state_d = ST_WR_HOLD;
            end
            ST_WR_HOLD: begin
                oe_d     = 1'b0;
                buf_free = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
            pix_data   <= '0;
            pix_valid  <= 1'b0;
            rd_shift   <= '0;
        end else begin
            state      <= state_d;
            sram_addr  <= addr_d;
            sram_dq_o  <= dq_d;
            sram_dq_oe <= oe_d;
            sram_we_n  <= we_n_d;
            pix_data   <= pix_d;
            pix_valid  <= valid_d;
            rd_shift   <= rd_shift_d;
        end
    end

endmodule

// File: tb/tb_sram_bmp_ctrl.sv
// Directed bench for sram_bmp_ctrl with a behavioural async SRAM model.
module tb_sram_bmp_ctrl;

    localparam int unsigned AW = 19;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b1;
    logic          ioctl_download = 1'b0;
    logic          ioctl_wr = 1'b0;
    logic [24:0]   ioctl_addr = '0;
    logic [7:0]    ioctl_dout = '0;
    logic          pix_req = 1'b0;
    logic [AW-3:0] pix_addr = '0;
    logic [31:0]   pix_data;
    logic          pix_valid;
    logic          bmp_loaded;
    logic          ovf;
    logic [AW-1:0] sram_addr;
    logic [7:0]    sram_dq_o;
    logic [7:0]    sram_dq_i;
    logic          sram_dq_oe;
    logic          sram_we_n;

    logic [7:0] mem [0:(1<<AW)-1];
    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt = 0;

    sram_bmp_ctrl #(.SRAM_AW(AW)) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .pix_req        (pix_req),
        .pix_addr       (pix_addr),
        .pix_data       (pix_data),
        .pix_valid      (pix_valid),
        .bmp_loaded     (bmp_loaded),
        .ovf            (ovf),
        .sram_addr      (sram_addr),
        .sram_dq_o      (sram_dq_o),
        .sram_dq_i      (sram_dq_i),
        .sram_dq_oe     (sram_dq_oe),
        .sram_we_n      (sram_we_n)
    );

    always #5 clk_sys = ~clk_sys;

    assign sram_dq_i = mem[sram_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // SRAM latches data on the rising edge of its write strobe
    always @(posedge sram_we_n) begin
        if (reset_n) begin
            mem[sram_addr] = sram_dq_o;
            wr_cnt++;
        end
    end

    always @(negedge clk_sys) begin
        if (reset_n && !sram_we_n) check("we_needs_oe", 32'(sram_dq_oe), 32'd1);
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
        repeat (5) tick();
    endtask

    task automatic send_header(input logic [7:0] ofs);
        for (int i = 0; i < 13; i++) begin
            logic [7:0] b;
            b = 8'h42;
            if (i == 10) b = ofs;
            else if (i == 11 || i == 12) b = 8'h00;
            send_byte(25'(i), b);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            n++;
            if (pix_valid) break;
        end
    endtask

    task automatic count_valid(input int cycles, output int v);
        v = 0;
        for (int k = 0; k < cycles; k++) begin
            tick();
            if (pix_valid) v++;
        end
    endtask

    initial begin
        int n;
        int v;
        logic [7:0] img [0:7];
        img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h23, 8'h45, 8'h67};

        // Reset state
        #1 reset_n = 1'b0;
        #2;
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_oe", 32'(sram_dq_oe), 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_pix_data", pix_data, 32'd0);
        check("rst_flags", {29'd0, pix_valid, bmp_loaded, ovf}, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Download 1: offset 0x36, image bytes at 0x36..0x3D
        ioctl_download = 1'b1;
        tick();
        send_header(8'h36);
        for (int a = 13; a < 'h36; a++) send_byte(25'(a), 8'h11);
        check("no_pre_data_writes", 32'(wr_cnt), 32'd0);
        for (int i = 0; i < 8; i++) send_byte(25'('h36 + i), img[i]);
        ioctl_download = 1'b0;
        repeat (3) tick();
        check("dl1_wr_cnt", 32'(wr_cnt), 32'd8);
        check("dl1_mem0_3", {mem[0], mem[1], mem[2], mem[3]}, 32'hAABBCCDD);
        check("dl1_mem4_7", {mem[4], mem[5], mem[6], mem[7]}, 32'h01234567);
        check("dl1_loaded", 32'(bmp_loaded), 32'd1);
        check("dl1_ovf", 32'(ovf), 32'd0);

        // Pixel read, 5-cycle latency
        pix_req  = 1'b1;
        pix_addr = '0;
        tick();
        pix_req = 1'b0;
        wait_valid(n);
        check("rd_latency", 32'(n), 32'd5);
        check("rd_data", pix_data, 32'hAABBCCDD);
        tick();
        check("rd_valid_pulse", 32'(pix_valid), 32'd0);

        // Back-to-back requests: a later request overwrites the pending address
        pix_req  = 1'b1;
        pix_addr = 17'd0;
        tick();
        pix_req = 1'b0;
        tick();
        pix_req  = 1'b1;
        pix_addr = 17'd0;
        tick();
        pix_addr = 17'd1;
        tick();
        pix_req = 1'b0;
        wait_valid(n);
        check("b2b_first_lat", 32'(n), 32'd2);
        check("b2b_first_data", pix_data, 32'hAABBCCDD);
        wait_valid(n);
        check("b2b_second_lat", 32'(n), 32'd5);
        check("b2b_latest_wins", pix_data, 32'h01234567);
        count_valid(12, v);
        check("b2b_no_extra", 32'(v), 32'd0);

        // Download 2: offset 0x10, range boundary, read request during download
        ioctl_download = 1'b1;
        tick();
        check("dl2_loaded_clr", 32'(bmp_loaded), 32'd0);
        send_header(8'h10);
        send_byte(25'h10, 8'h5A);
        pix_req  = 1'b1;
        pix_addr = '0;
        tick();
        pix_req = 1'b0;
        count_valid(10, v);
        check("dl_req_discard", 32'(v), 32'd0);
        check("dl_pix_hold", pix_data, 32'h01234567);
        send_byte(25'h8000F, 8'hE7);
        check("top_addr_mem", 32'(mem[(1<<AW)-1]), 32'hE7);
        check("top_addr_no_ovf", 32'(ovf), 32'd0);
        send_byte(25'h80010, 8'hF0);
        check("range_ovf", 32'(ovf), 32'd1);
        check("range_no_write", 32'(wr_cnt), 32'd10);

        // Last byte fills the buffer while a read request arrives
        ioctl_addr = 25'h11;
        ioctl_dout = 8'h77;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        pix_req        = 1'b1;
        pix_addr       = '0;
        tick();
        pix_req = 1'b0;
        wait_valid(n);
        check("wr_first_latency", 32'(n), 32'd8);
        check("wr_first_data", pix_data, 32'h5A77CCDD);
        repeat (2) tick();
        check("dl2_loaded", 32'(bmp_loaded), 32'd1);
        check("dl2_ovf_sticky", 32'(ovf), 32'd1);

        // Download 3: two strobes too close together
        ioctl_download = 1'b1;
        tick();
        check("dl3_ovf_clr", 32'(ovf), 32'd0);
        send_header(8'h20);
        ioctl_addr = 25'h20;
        ioctl_dout = 8'h11;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        tick();
        ioctl_addr = 25'h21;
        ioctl_dout = 8'h22;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        repeat (5) tick();
        check("close_ovf", 32'(ovf), 32'd1);
        check("close_mem", {16'd0, mem[0], mem[1]}, 32'h00001177);
        ioctl_download = 1'b0;
        repeat (3) tick();
        check("dl3_loaded", 32'(bmp_loaded), 32'd1);

        // Download 4: reset during the write pulse
        ioctl_download = 1'b1;
        tick();
        send_header(8'h20);
        ioctl_addr = 25'h22;
        ioctl_dout = 8'h99;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        tick();
        tick();
        check("pulse_we_n", 32'(sram_we_n), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        check("abort_we_n", 32'(sram_we_n), 32'd1);
        check("abort_oe", 32'(sram_dq_oe), 32'd0);
        check("abort_loaded", 32'(bmp_loaded), 32'd0);
        ioctl_download = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        repeat (4) tick();
        check("abort_no_write", 32'(wr_cnt), 32'd12);
        check("abort_mem2", 32'(mem[2]), 32'hCC);
        check("abort_not_loaded", 32'(bmp_loaded), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
